rr_arb_4to1: RTL and testbench

//  Round-robin arbiter for four requesters. Generates the 2-bit select and the
//  one-hot grant that steer a downstream 4:1 data multiplexer.

---
 rtl/arb_pkg.sv | 17 +
 rtl/rr_arb_4to1_pick4.sv | 31 +++
 rtl/rr_arb_4to1.sv | 97 +++++++++
 tb/tb_rr_arb_4to1.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants, state type and helpers for the 4-way round-robin arbiter.
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  // Convert a requester index into its one-hot grant vector.
  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/rr_arb_4to1_pick4.sv
// Rotating priority search: first unmasked request starting at ptr, wrapping mod 4.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  input  logic [N_REQ-1:0] mask,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [N_REQ-1:0] cand_req;
  logic [SEL_W-1:0] pos;

  assign cand_req = req & ~mask;

  // Walk ptr, ptr+1, ... and latch the first candidate seen.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    pos   = ptr;
    for (int i = 0; i < N_REQ; i++) begin
      pos = ptr + SEL_W'(i);
      if (!found && cand_req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/rr_arb_4to1.sv
// Round-robin 4:1 arbiter producing registered select/one-hot grant with
// valid/ready output and per-tenure burst limit. No bubble on re-arbitration.
module rr_arb_4to1
  import arb_pkg::*;
#(
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] gnt
);

  localparam int              CNT_W     = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);

  arb_state_t       state;
  logic [SEL_W-1:0] ptr;
  logic [CNT_W-1:0] beat_cnt;

  logic             accept;
  logic             release_now;
  logic [SEL_W-1:0] pick_ptr;
  logic [N_REQ-1:0] pick_mask;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;

  assign accept = out_valid & out_ready;

  // Tenure ends on the burst-final beat, on the holder's last beat, or when
  // the holder withdraws its request without being accepted.
  assign release_now = (accept && (beat_cnt == LAST_BEAT)) || !req[sel];

  // While granting, search from the pointer the release will set and skip the
  // current holder so it cannot immediately win again.
  always_comb begin
    pick_ptr  = ptr;
    pick_mask = '0;
    if (state == GRANT) begin
      pick_ptr  = sel + 2'd1;
      pick_mask = onehot(sel);
    end
  end

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .mask  (pick_mask),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // State, pointer, beat counter and registered grant outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      beat_cnt  <= '0;
      sel       <= '0;
      gnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            sel       <= pick_idx;
            gnt       <= onehot(pick_idx);
            out_valid <= 1'b1;
            beat_cnt  <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            ptr      <= sel + 2'd1;
            beat_cnt <= '0;
            if (pick_found) begin
              sel <= pick_idx;
              gnt <= onehot(pick_idx);
            end else begin
              gnt       <= '0;
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end else if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb_4to1.sv
// Directed bench for rr_arb_4to1: one instance with BURST=4, one with BURST=1.
module tb_rr_arb_4to1;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       rdy;
  logic       out_valid;
  logic [1:0] sel;
  logic [3:0] gnt;

  logic [3:0] req1;
  logic       rdy1;
  logic       out_valid1;
  logic [1:0] sel1;
  logic [3:0] gnt1;

  int checks;
  int failures;

  rr_arb_4to1 #(.BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_ready (rdy),
    .out_valid (out_valid),
    .sel       (sel),
    .gnt       (gnt)
  );

  rr_arb_4to1 #(.BURST(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .req       (req1),
    .out_ready (rdy1),
    .out_valid (out_valid1),
    .sel       (sel1),
    .gnt       (gnt1)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [3:0] r, input logic ready);
    req = r;
    rdy = ready;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Directed sequence covering reset, burst rotation, backpressure, wrap and drop.
  initial begin
    logic [1:0] exp_sel;
    logic [3:0] exp_gnt;
    checks   = 0;
    failures = 0;
    rst  = 1'b1;
    req  = 4'b0000;
    rdy  = 1'b0;
    req1 = 4'b0000;
    rdy1 = 1'b0;
    repeat (2) step();

    check_output("reset_gnt", 32'(gnt), 32'h0);
    check_output("reset_sel", 32'(sel), 32'h0);
    check_output("reset_valid", 32'(out_valid), 32'h0);
    check_output("reset_valid_b1", 32'(out_valid1), 32'h0);
    rst = 1'b0;

    $display("[TB] BURST=1 alternation");
    req1 = 4'b0101;
    rdy1 = 1'b1;
    check_output("b1_valid_before_edge", 32'(out_valid1), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      exp_sel = (i % 2 == 0) ? 2'd0 : 2'd2;
      exp_gnt = (i % 2 == 0) ? 4'b0001 : 4'b0100;
      check_output("b1_sel", 32'(sel1), 32'(exp_sel));
      check_output("b1_gnt", 32'(gnt1), 32'(exp_gnt));
      check_output("b1_valid", 32'(out_valid1), 32'h1);
    end
    req1 = 4'b0000;
    rdy1 = 1'b0;
    step();
    check_output("b1_idle_gnt", 32'(gnt1), 32'h0);
    check_output("b1_idle_valid", 32'(out_valid1), 32'h0);

    $display("[TB] BURST=4 two requesters");
    apply_stimulus(4'b0011, 1'b1);
    for (int i = 0; i < 9; i++) begin
      step();
      exp_sel = (i < 4) ? 2'd0 : ((i < 8) ? 2'd1 : 2'd0);
      exp_gnt = (i < 4) ? 4'b0001 : ((i < 8) ? 4'b0010 : 4'b0001);
      check_output("b4_sel", 32'(sel), 32'(exp_sel));
      check_output("b4_gnt", 32'(gnt), 32'(exp_gnt));
    end

    $display("[TB] backpressure mid-burst");
    step();
    check_output("bp_cnt_start", 32'(dut.beat_cnt), 32'h1);
    apply_stimulus(4'b0011, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_output("bp_sel", 32'(sel), 32'h0);
      check_output("bp_gnt", 32'(gnt), 32'h1);
      check_output("bp_valid", 32'(out_valid), 32'h1);
      check_output("bp_cnt", 32'(dut.beat_cnt), 32'h1);
    end
    apply_stimulus(4'b0011, 1'b1);
    step();
    check_output("bp_resume_cnt2", 32'(dut.beat_cnt), 32'h2);
    step();
    check_output("bp_resume_cnt3", 32'(dut.beat_cnt), 32'h3);
    check_output("bp_resume_sel", 32'(sel), 32'h0);
    step();
    check_output("bp_done_sel", 32'(sel), 32'h1);
    check_output("bp_done_gnt", 32'(gnt), 32'h2);
    check_output("bp_done_cnt", 32'(dut.beat_cnt), 32'h0);

    $display("[TB] asynchronous reset mid-grant");
    apply_stimulus(4'b0100, 1'b0);
    step();
    check_output("pre_reset_gnt", 32'(gnt), 32'h4);
    #2;
    rst = 1'b1;
    #1;
    check_output("async_gnt", 32'(gnt), 32'h0);
    check_output("async_sel", 32'(sel), 32'h0);
    check_output("async_valid", 32'(out_valid), 32'h0);
    step();
    rst = 1'b0;
    apply_stimulus(4'b0001, 1'b0);
    step();
    check_output("post_reset_sel", 32'(sel), 32'h0);
    check_output("post_reset_gnt", 32'(gnt), 32'h1);

    $display("[TB] pointer wrap");
    apply_stimulus(4'b1000, 1'b0);
    step();
    check_output("wrap_sel3", 32'(sel), 32'h3);
    check_output("wrap_gnt3", 32'(gnt), 32'h8);
    apply_stimulus(4'b1001, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      exp_sel = (i < 3) ? 2'd3 : 2'd0;
      exp_gnt = (i < 3) ? 4'b1000 : 4'b0001;
      check_output("wrap_sel", 32'(sel), 32'(exp_sel));
      check_output("wrap_gnt", 32'(gnt), 32'(exp_gnt));
    end

    $display("[TB] request drop without accept");
    apply_stimulus(4'b0010, 1'b0);
    step();
    check_output("drop_setup_sel", 32'(sel), 32'h1);
    apply_stimulus(4'b0110, 1'b0);
    step();
    check_output("drop_hold_sel", 32'(sel), 32'h1);
    apply_stimulus(4'b0100, 1'b0);
    step();
    check_output("drop_sel", 32'(sel), 32'h2);
    check_output("drop_gnt", 32'(gnt), 32'h4);
    check_output("drop_cnt", 32'(dut.beat_cnt), 32'h0);
    check_output("drop_ptr", 32'(dut.ptr), 32'h2);
    apply_stimulus(4'b0000, 1'b0);
    step();
    check_output("final_idle_gnt", 32'(gnt), 32'h0);
    check_output("final_idle_valid", 32'(out_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
